// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor controller: button indices, FSM state
// encoding and the per-axis step arithmetic used for both X and Y.
package cursor_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // One axis move: pos + dir*step, then clamped or wrapped into [0, max_v].
    // Signed arithmetic so a step below zero is seen as negative.
    function automatic int axis_step(input int pos, input int dir, input int step,
                                     input int max_v, input bit wrap);
        int n;
        n = pos + dir * step;
        if (wrap) begin
            if (n < 0)
                n = n + max_v + 1;
            else if (n > max_v)
                n = n - max_v - 1;
        end else begin
            if (n < 0)
                n = 0;
            else if (n > max_v)
                n = max_v;
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: two-flop synchroniser followed by a
// tick-counted debouncer. The level only follows the synchronised input once
// it has disagreed with the level for DB_TICKS consecutive ticks; any cycle
// of agreement restarts the count.
module btn_debounce #(
    parameter int DB_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DB_TICKS + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count ticks of sustained disagreement and flip the level when enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CW'(DB_TICKS - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor position controller: four debounced buttons drive registered X/Y
// coordinates with diagonal moves, configurable step, edge clamping and
// auto-repeat while held.
// Optional feature macro CURSOR_CTRL_WRAP_EN: when defined, coordinates wrap
// around the edges instead of clamping, and every move event pulses moved.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int W         = 10,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int DEFAULT_X = 320,
    parameter int DEFAULT_Y = 240,
    parameter int TICK_DIV  = 15,
    parameter int DB_TICKS  = 4,
    parameter int STEP      = 1,
    parameter int RPT_DELAY = 32,
    parameter int RPT_RATE  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   btn,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         moved,
    output logic [3:0]   held
);

`ifdef CURSOR_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int CW      = $clog2(RPT_MAX + 1);

    if (STEP > X_MAX || STEP > Y_MAX || DEFAULT_X > X_MAX || DEFAULT_Y > Y_MAX ||
        X_MAX >= (1 << W) || Y_MAX >= (1 << W)) begin : g_param_check
        $error("cursor_ctrl: illegal parameter combination");
    end

    logic [TICK_DIV-1:0] tcnt;
    logic                tick;
    state_t              state;
    logic [CW-1:0]       rpt_cnt;
    int                  dx;
    int                  dy;
    logic                act;
    logic [W-1:0]        x_new;
    logic [W-1:0]        y_new;
    logic                moved_nxt;
    logic                do_move;

    // Free-running tick prescaler; tick is high when the counter is all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign tick = &tcnt;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DB_TICKS(DB_TICKS)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (btn[i]),
            .level(held[i])
        );
    end

    // Direction from debounced levels, candidate position and move decision.
    always_comb begin
        dx = 0;
        dy = 0;
        if (held[BTN_RIGHT] && !held[BTN_LEFT])
            dx = 1;
        else if (held[BTN_LEFT] && !held[BTN_RIGHT])
            dx = -1;
        if (held[BTN_DOWN] && !held[BTN_UP])
            dy = 1;
        else if (held[BTN_UP] && !held[BTN_DOWN])
            dy = -1;
        act       = (dx != 0) || (dy != 0);
        x_new     = W'(axis_step(int'(x), dx, STEP, X_MAX, WRAP));
        y_new     = W'(axis_step(int'(y), dy, STEP, Y_MAX, WRAP));
        moved_nxt = WRAP || (x_new != x) || (y_new != y);
        do_move   = 1'b0;
        case (state)
            IDLE:    do_move = act;
            DELAY:   do_move = act && tick && (rpt_cnt == CW'(RPT_DELAY - 1));
            REPEAT:  do_move = act && tick && (rpt_cnt == CW'(RPT_RATE - 1));
            default: do_move = 1'b0;
        endcase
    end

    // Press / delay / repeat sequencing with registered coordinates and pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            x       <= W'(DEFAULT_X);
            y       <= W'(DEFAULT_Y);
            moved   <= 1'b0;
        end else begin
            moved <= 1'b0;
            if (do_move) begin
                x     <= x_new;
                y     <= y_new;
                moved <= moved_nxt;
            end
            case (state)
                IDLE: begin
                    if (act) begin
                        state   <= DELAY;
                        rpt_cnt <= '0;
                    end
                end
                DELAY: begin
                    if (!act) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (do_move) begin
                            state   <= REPEAT;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!act) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (do_move)
                            rpt_cnt <= '0;
                        else
                            rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
